// File: rtl/change_dispenser.sv
// Change dispenser: breaks a cent amount into quarters, dimes and nickels
// (largest coin first) and presents them one at a time to a coin ejector,
// waiting for the ejector's acknowledge before moving on to the next coin.
module change_dispenser #(
  parameter int unsigned COIN_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       coin_ack,
  output logic       N_out,
  output logic       D_out,
  output logic       Q_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] remaining,
  output logic [5:0] coin_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] C_N = 2'd0;
  localparam logic [1:0] C_D = 2'd1;
  localparam logic [1:0] C_Q = 2'd2;

  // GAP counts down from COIN_GAP-1 to 0, so it spans exactly COIN_GAP cycles.
  localparam logic [3:0] GAP_LOAD = (COIN_GAP > 0) ? 4'(COIN_GAP - 1) : 4'd0;

  logic [2:0] state;
  logic [1:0] coin;
  logic [7:0] remaining_r;
  logic [5:0] coin_cnt_r;
  logic [3:0] gap_cnt;
  logic       reject_r;

  logic [7:0] coin_val;
  logic [7:0] rem_after;
  logic [1:0] pick;

  // Value of the coin being presented, the balance after it, and the next coin.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    coin_val = 8'd5;
    pick     = C_N;
    case (coin)
      C_D:     coin_val = 8'd10;
      C_Q:     coin_val = 8'd25;
      default: coin_val = 8'd5;
    endcase
    if (remaining_r >= 8'd25)      pick = C_Q;
    else if (remaining_r >= 8'd10) pick = C_D;
    else                           pick = C_N;
    // Coin is always chosen not to exceed the balance, so this cannot underflow.
    rem_after = remaining_r - coin_val;
  end

  // Request FSM with balance, coin counter and gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      coin        <= C_N;
      remaining_r <= 8'd0;
      coin_cnt_r  <= 6'd0;
      gap_cnt     <= 4'd0;
      reject_r    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, regardless of statement order.
      reject_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if ((amount % 8'd5) != 8'd0) begin
              reject_r <= 1'b1;
            end else if (amount == 8'd0) begin
              coin_cnt_r <= 6'd0;
              state      <= S_DONE;
            end else begin
              remaining_r <= amount;
              coin_cnt_r  <= 6'd0;
              state       <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          coin  <= pick;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (coin_ack) begin
            remaining_r <= rem_after;
            if (coin_cnt_r != 6'h3F) coin_cnt_r <= coin_cnt_r + 6'd1;
            if (rem_after == 8'd0) begin
              state <= S_DONE;
            end else if (COIN_GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              state <= S_SELECT;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_SELECT;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    N_out     = (state == S_ISSUE) && (coin == C_N);
    D_out     = (state == S_ISSUE) && (coin == C_D);
    Q_out     = (state == S_ISSUE) && (coin == C_Q);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE) || reject_r;
    err       = reject_r;
    remaining = remaining_r;
    coin_cnt  = coin_cnt_r;
  end

endmodule
